// File: rtl/bamse_io_pkg.sv
// ============================================================================
// Module : bamse_io_pkg
// Brief  : Shared constants and IRQ state encoding for the bamse input side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bamse_io_pkg;

  localparam int CLK_HZ              = 32_000_000;
  // 10 ms of stable level at the 32 MHz system clock
  localparam int DEBOUNCE_CYCLES_DEF = 320_000;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } irq_state_t;

endpackage : bamse_io_pkg

`default_nettype wire

// File: rtl/bamse_debounce.sv
// ============================================================================
// Module : bamse_debounce
// Brief  : One-bit 2-flop synchroniser, stability counter and stable register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bamse_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic q,
  output logic upd
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_st;
  logic             r_upd;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_st    <= 1'b0;
      r_upd   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= d_raw;
      r_sync2 <= r_sync1;
      r_upd   <= 1'b0;
      // Any cycle agreeing with the stable level restarts the count
      if (r_sync2 == r_st) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_st  <= r_sync2;
        r_cnt <= '0;
        r_upd <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign q   = r_st;
  assign upd = r_upd;

endmodule : bamse_debounce

`default_nettype wire

// File: rtl/bamse_in_cond.sv
// ============================================================================
// Module : bamse_in_cond
// Brief  : Switch/button conditioner: debounced port B data and held IRQ.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bamse_in_cond
  import bamse_io_pkg::*;
#(
  parameter int NSW             = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NSW-1:0] sw_raw,
  input  logic           btn_raw,
  input  logic           irq_ack,
  output logic [NSW-1:0] portB_in,
  output logic           sw_changed,
  output logic           irq,
  output logic           irq_overrun
);

  logic [NSW:0] w_raw;
  logic [NSW:0] w_st;
  logic [NSW:0] w_upd;
  logic         w_rise;

  logic         r_btn_st_d;
  logic         r_sw_changed;
  irq_state_t   r_state;
  logic         r_irq;
  logic         r_overrun;

  // Button rides as the top channel alongside the switches
  assign w_raw = {btn_raw, sw_raw};

  generate
    for (genvar i = 0; i <= NSW; i++) begin : g_chan
      bamse_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .d_raw (w_raw[i]),
        .q     (w_st[i]),
        .upd   (w_upd[i])
      );
    end
  endgenerate

  // upd is high exactly when the delayed copy still lags, so this is a pure rising edge
  assign w_rise = w_upd[NSW] & w_st[NSW] & ~r_btn_st_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_st_d   <= 1'b0;
      r_sw_changed <= 1'b0;
    end else begin
      r_btn_st_d   <= w_st[NSW];
      r_sw_changed <= |w_upd[NSW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_irq     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= PEND;
            r_irq   <= 1'b1;
          end
        end
        PEND: begin
          if (irq_ack) begin
            // A press landing on the ack becomes the next request
            if (!w_rise) begin
              r_state <= IDLE;
              r_irq   <= 1'b0;
            end
            r_overrun <= 1'b0;
          end else if (w_rise) begin
            r_overrun <= 1'b1;
          end
        end
      endcase
    end
  end

  assign portB_in    = w_st[NSW-1:0];
  assign sw_changed  = r_sw_changed;
  assign irq         = r_irq;
  assign irq_overrun = r_overrun;

endmodule : bamse_in_cond

`default_nettype wire

// File: tb/tb_bamse_in_cond.sv
// ============================================================================
// Module : tb_bamse_in_cond
// Brief  : Directed self-checking bench for bamse_in_cond, DEBOUNCE_CYCLES=4.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bamse_in_cond;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw_raw;
  logic       btn_raw;
  logic       irq_ack;
  logic [7:0] portB_in;
  logic       sw_changed;
  logic       irq;
  logic       irq_overrun;

  int n_checks = 0;
  int n_errors = 0;

  bamse_in_cond #(
    .NSW             (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .btn_raw     (btn_raw),
    .irq_ack     (irq_ack),
    .portB_in    (portB_in),
    .sw_changed  (sw_changed),
    .irq         (irq),
    .irq_overrun (irq_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
  endtask

  initial begin
    int n_pulse;
    int n_bad;

    rst = 1'b0; sw_raw = 8'hA5; btn_raw = 1'b0; irq_ack = 1'b0;

    // 1: reset state, then release and settle on A5
    step(3);
    check("rst_portB", portB_in, 8'h00);
    check("rst_swchg", sw_changed, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_ovr", irq_overrun, 1'b0);
    @(posedge clk); #1; rst = 1'b1;      // edge 0
    step(5);
    check("settle_e5", portB_in, 8'h00);
    step(1);
    check("settle_e6", portB_in, 8'hA5);
    check("swchg_e6", sw_changed, 1'b0);
    step(1);
    check("swchg_e7", sw_changed, 1'b1);
    step(1);
    check("swchg_e8", sw_changed, 1'b0);

    // 2: short glitch on bit 0 never propagates
    sw_raw = 8'hA4;
    step(10);
    check("bit0_low", portB_in, 8'hA4);
    sw_raw = 8'hA5;
    step(3);
    sw_raw = 8'hA4;
    n_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (portB_in !== 8'hA4 || sw_changed !== 1'b0) n_bad++;
      step(1);
    end
    check("glitch", n_bad, 0);

    // 3: held button gives one request, cleared by ack
    btn_raw = 1'b1;
    step(6);
    check("btn_e6_irq", irq, 1'b0);
    step(1);
    check("btn_e7_irq", irq, 1'b1);
    step(13);
    check("btn_hold_irq", irq, 1'b1);
    ack_pulse();
    check("ack_clears", irq, 1'b0);
    step(5);
    check("no_rearm", irq, 1'b0);
    btn_raw = 1'b0;
    step(8);

    // 4: second press while pending sets overrun; ack clears both
    btn_raw = 1'b1; step(8);
    check("p1_irq", irq, 1'b1);
    check("p1_ovr", irq_overrun, 1'b0);
    btn_raw = 1'b0; step(8);
    btn_raw = 1'b1; step(8);
    check("p2_irq", irq, 1'b1);
    check("p2_ovr", irq_overrun, 1'b1);
    btn_raw = 1'b0; step(8);
    check("ovr_sticky", irq_overrun, 1'b1);
    ack_pulse();
    check("ovr_ack_irq", irq, 1'b0);
    check("ovr_ack_ovr", irq_overrun, 1'b0);

    // 5: ack coincident with a new rise keeps the request
    btn_raw = 1'b1; step(8);
    check("c_p1_irq", irq, 1'b1);
    btn_raw = 1'b0; step(8);
    btn_raw = 1'b1; step(6);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    check("coinc_irq", irq, 1'b1);
    check("coinc_ovr", irq_overrun, 1'b0);
    step(3);
    check("coinc_hold", irq, 1'b1);
    ack_pulse();
    check("coinc_ack2", irq, 1'b0);
    ack_pulse();
    check("idle_ack", irq, 1'b0);
    btn_raw = 1'b0; step(8);

    // 6: async reset mid-debounce and mid-pending
    btn_raw = 1'b1; step(8);
    btn_raw = 1'b0; step(8);
    btn_raw = 1'b1; step(8);
    check("r_pre_irq", irq, 1'b1);
    check("r_pre_ovr", irq_overrun, 1'b1);
    sw_raw = 8'h3C;
    step(2);
    #2 rst = 1'b0;
    #1;
    check("arst_irq", irq, 1'b0);
    check("arst_ovr", irq_overrun, 1'b0);
    check("arst_portB", portB_in, 8'h00);
    sw_raw = 8'h00; btn_raw = 1'b0;
    step(3);
    check("arst_hold", portB_in, 8'h00);
    rst = 1'b1;
    n_pulse = 0;
    n_bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (sw_changed) n_pulse++;
      if (irq || portB_in !== 8'h00) n_bad++;
    end
    check("post_rst_pulse", n_pulse, 0);
    check("post_rst_quiet", n_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bamse_in_cond

`default_nettype wire
